rx_channel_controller: RTL and testbench
========================================

RX_CHANNEL_CONTROLLER -- requirements
Module: rx_channel_controller

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, 8, cycles from tune strobe to lock (legal range 1-255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 32, maximum lock wait when LOCK_TIMEOUT_EN is defined (must exceed SETTLE_CYCLES).
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port node_id  input  16  own node id.
REQ-006 SHALL have port max_node  input  16  number of nodes in the ring.
REQ-007 SHALL have port data_rx_node_id  input  16  requested source node from the node's comms processor.
REQ-008 SHALL have port lock_ok  input  1  photonic driver lock indication (used only with LOCK_TIMEOUT_EN).
REQ-009 SHALL have port channel_sel  output  16  wavelength/spatial channel index driven to the receiver tuner.
REQ-010 SHALL have port tune_en  output  1  one-cycle strobe: tuner loads channel_sel.
REQ-011 SHALL have port rx_locked  output  1  receiver settled on channel_sel.
REQ-012 SHALL have port rx_error  output  1  last request invalid or lock failed.
REQ-013 SHALL have port retune_count  output  8  saturating count of tune_en strobes.

Function
REQ-014 SHALL implement FSM IDLE, TUNE, SETTLE, LOCKED, ERROR.
REQ-015 SHALL register request: request pending when data_rx_node_id != channel_sel in IDLE, SETTLE or LOCKED, or when data_rx_node_id changes in ERROR.
REQ-016 SHALL treat request valid iff data_rx_node_id < max_node and data_rx_node_id != node_id.
REQ-017 SHALL on valid request go to TUNE next cycle; in TUNE assert tune_en for exactly one cycle with channel_sel = requested id, deassert rx_locked, then enter SETTLE.
REQ-018 SHALL on invalid request enter ERROR next cycle: rx_error=1, rx_locked=0, channel_sel unchanged, no tune_en.
REQ-019 SHALL in SETTLE count SETTLE_CYCLES cycles, then enter LOCKED; rx_locked rises exactly SETTLE_CYCLES+1 cycles after the tune_en cycle.
REQ-020 SHALL abandon SETTLE or LOCKED on a new request and return to TUNE (valid) or ERROR (invalid); settle counter reloads on each TUNE.
REQ-021 SHALL leave ERROR only on a valid request, via TUNE; rx_error clears in the TUNE cycle.
REQ-022 SHALL increment retune_count on each tune_en and saturate at 255.
REQ-023 SHALL latch max_node and node_id only at request sampling; mid-settle changes to them do not abort tuning.

Reset
REQ-024 SHALL on rst low immediately force state IDLE, channel_sel=16'hFFFF (NO_CHANNEL), tune_en=0, rx_locked=0, rx_error=0, retune_count=0.
REQ-025 SHALL, since channel_sel=NO_CHANNEL after reset, treat any valid id as a pending request in the first cycle after release.

Configuration
REQ-026 SHALL with RX_CHAN_LOCK_TIMEOUT_EN defined: in SETTLE, after SETTLE_CYCLES expire, wait for lock_ok; enter LOCKED on lock_ok, or ERROR if not seen by TIMEOUT_CYCLES after tune_en.
REQ-027 SHALL without RX_CHAN_LOCK_TIMEOUT_EN: lock_ok ignored, lock purely by settle count, ERROR only from invalid requests.

Structure
REQ-028 SHALL place FSM state enum, NO_CHANNEL constant and node-id width in shared package rx_chan_pkg.
REQ-029 SHALL implement settle/timeout counting in one sub-module settle_timer (load, count, expire).

Verification
REQ-030 SHALL cover: release reset, max_node=4, node_id=0, data_rx_node_id=2 -> tune_en 1 cycle with channel_sel=2, rx_locked high 9 cycles later, retune_count=1.
REQ-031 SHALL cover: data_rx_node_id=5 with max_node=4, and separately =node_id -> rx_error=1, no tune_en, channel_sel unchanged.
REQ-032 SHALL cover: request 1, then 3 at settle cycle 4 -> second tune_en with channel_sel=3, rx_locked only 9 cycles after second strobe.
REQ-033 SHALL cover: rst low during SETTLE -> all outputs at reset values same cycle; after release pending id retunes.
REQ-034 SHALL cover: 300 alternating valid requests -> retune_count saturates at 255.
REQ-035 SHALL cover: with RX_CHAN_LOCK_TIMEOUT_EN, lock_ok never asserted -> rx_error=1 at cycle 32 after tune_en; lock_ok at cycle 12 -> LOCKED.

Source files
------------

// File: rtl/rx_chan_pkg.sv
// rx_chan_pkg: shared definitions for the receive channel controller.
//   NODE_ID_W  : width of node ids and channel indices
//   NO_CHANNEL : channel_sel value meaning "receiver not tuned"
//   rx_state_e : controller FSM states
package rx_chan_pkg;

    localparam int unsigned NODE_ID_W = 16;

    localparam logic [NODE_ID_W-1:0] NO_CHANNEL = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StTune,
        StSettle,
        StLocked,
        StError
    } rx_state_e;

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter used for tuner settle and lock timeout.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   load       : load load_value into the counter (has priority over count_en)
//   load_value : number of counting cycles until expiry
//   count_en   : decrement the counter this cycle
//   expire     : high in the final counting cycle (counter at 1 while counting)
//   done       : counter has run out (0)
module settle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             expire,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (count_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = count_en && (cnt_q == WIDTH'(1));
    assign done   = (cnt_q == '0);

endmodule

// File: rtl/rx_channel_controller.sv
// rx_channel_controller: tunes the photonic receiver to the source node
// requested by the comms processor and reports lock / error status.
// Optional feature macro: RX_CHAN_LOCK_TIMEOUT_EN (wait for lock_ok after
// settling, with an error if lock is not seen within TIMEOUT_CYCLES).
//   clk             : system clock
//   rst             : asynchronous active-low reset
//   node_id         : own node id
//   max_node        : number of nodes in the ring
//   data_rx_node_id : requested source node
//   lock_ok         : driver lock indication (timeout build only)
//   channel_sel     : channel index to the receiver tuner
//   tune_en         : one-cycle strobe, tuner loads channel_sel
//   rx_locked       : receiver settled on channel_sel
//   rx_error        : last request invalid or lock failed
//   retune_count    : saturating count of tune_en strobes
module rx_channel_controller
    import rx_chan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NODE_ID_W-1:0] node_id,
    input  logic [NODE_ID_W-1:0] max_node,
    input  logic [NODE_ID_W-1:0] data_rx_node_id,
    input  logic                 lock_ok,
    output logic [NODE_ID_W-1:0] channel_sel,
    output logic                 tune_en,
    output logic                 rx_locked,
    output logic                 rx_error,
    output logic [7:0]           retune_count
);

    localparam int unsigned TIMEOUT_W = 16;

    rx_state_e            state_q, state_d;
    logic [NODE_ID_W-1:0] chan_q, chan_d;
    logic [NODE_ID_W-1:0] req_q, req_d;
    logic [7:0]           count_q, count_d;

    logic pending;
    logic req_valid;
    logic timer_load;
    logic timer_count;
    logic settle_expire;
    logic settle_done;

    assign timer_load  = (state_q == StTune);
    assign timer_count = (state_q == StSettle);

    settle_timer #(
        .WIDTH (8)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (8'(SETTLE_CYCLES)),
        .count_en   (timer_count),
        .expire     (settle_expire),
        .done       (settle_done)
    );

`ifdef RX_CHAN_LOCK_TIMEOUT_EN
    logic timeout_expire;
    logic timeout_done;
    logic unused_timeout_done;

    // Loaded in the tune cycle with one less than the limit so the error
    // state is reached exactly TIMEOUT_CYCLES cycles after tune_en.
    settle_timer #(
        .WIDTH (TIMEOUT_W)
    ) u_timeout_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (TIMEOUT_W'(TIMEOUT_CYCLES - 1)),
        .count_en   (timer_count),
        .expire     (timeout_expire),
        .done       (timeout_done)
    );

    assign unused_timeout_done = timeout_done;
`else
    logic unused_lock;

    // Lock is decided purely by the settle count in this build.
    assign unused_lock = lock_ok ^ settle_done;
`endif

    assign req_valid = (data_rx_node_id < max_node) && (data_rx_node_id != node_id);

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        req_d   = req_q;
        count_d = count_q;
        pending = 1'b0;

        // In ERROR the channel still holds the old tune, so only a change of
        // the requested id counts as a new request.
        case (state_q)
            StIdle, StSettle, StLocked: pending = (data_rx_node_id != chan_q);
            StError:                    pending = (data_rx_node_id != req_q);
            default:                    pending = 1'b0;
        endcase

        case (state_q)
            StTune: state_d = StSettle;
`ifdef RX_CHAN_LOCK_TIMEOUT_EN
            StSettle: begin
                if ((settle_expire || settle_done) && lock_ok) begin
                    state_d = StLocked;
                end else if (timeout_expire) begin
                    state_d = StError;
                end
            end
`else
            StSettle: begin
                if (settle_expire) begin
                    state_d = StLocked;
                end
            end
`endif
            default: state_d = state_q;
        endcase

        // A new request overrides settling or lock in progress.
        if (pending) begin
            req_d = data_rx_node_id;
            if (req_valid) begin
                state_d = StTune;
                chan_d  = data_rx_node_id;
            end else begin
                state_d = StError;
            end
        end

        if ((state_d == StTune) && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            chan_q  <= NO_CHANNEL;
            req_q   <= NO_CHANNEL;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            req_q   <= req_d;
            count_q <= count_d;
        end
    end

    assign channel_sel  = chan_q;
    assign tune_en      = (state_q == StTune);
    assign rx_locked    = (state_q == StLocked);
    assign rx_error     = (state_q == StError);
    assign retune_count = count_q;

endmodule

// File: tb/tb_rx_channel_controller.sv
module tb_rx_channel_controller;

    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] node_id = 16'd0;
    logic [15:0] max_node = 16'd4;
    logic [15:0] data_rx_node_id = 16'd2;
    logic        lock_ok = 1'b1;
    logic [15:0] channel_sel;
    logic        tune_en;
    logic        rx_locked;
    logic        rx_error;
    logic [7:0]  retune_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rx_channel_controller #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .node_id         (node_id),
        .max_node        (max_node),
        .data_rx_node_id (data_rx_node_id),
        .lock_ok         (lock_ok),
        .channel_sel     (channel_sel),
        .tune_en         (tune_en),
        .rx_locked       (rx_locked),
        .rx_error        (rx_error),
        .retune_count    (retune_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: timestamps of tune events instead of FSM states.
    int          m_n;
    int          m_tune_at;
    int          m_tunes;
    logic [15:0] m_chan;
    logic [15:0] m_last_req;
    bit          m_err;
    bit          m_armed;

    task automatic model_reset();
        m_chan     = 16'hFFFF;
        m_last_req = 16'hFFFF;
        m_err      = 1'b0;
        m_armed    = 1'b0;
        m_tune_at  = -1;
        m_tunes    = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_chan"}, channel_sel, 16'hFFFF);
        chk({tag, "_tune"}, tune_en, 1'b0);
        chk({tag, "_locked"}, rx_locked, 1'b0);
        chk({tag, "_error"}, rx_error, 1'b0);
        chk({tag, "_count"}, retune_count, 8'd0);
    endtask

    // Check the current cycle against the model, let the model sample the
    // inputs, then move to just after the next rising edge.
    task automatic cycle();
        bit exp_tune;
        bit exp_locked;
        bit pending;
        @(negedge clk);
        exp_tune = (m_tune_at == m_n);
        if (exp_tune) m_tunes++;
        exp_locked = m_armed && !exp_tune && (m_n >= m_tune_at + SETTLE + 1);
        chk("tune_en", tune_en, exp_tune);
        chk("channel_sel", channel_sel, m_chan);
        chk("rx_locked", rx_locked, exp_locked);
        chk("rx_error", rx_error, m_err);
        chk("retune_count", retune_count, (m_tunes > 255) ? 255 : m_tunes);
        if (!exp_tune) begin
            pending = m_err ? (data_rx_node_id != m_last_req) : (data_rx_node_id != m_chan);
            if (pending) begin
                m_last_req = data_rx_node_id;
                if ((data_rx_node_id < max_node) && (data_rx_node_id != node_id)) begin
                    m_tune_at = m_n + 1;
                    m_chan    = data_rx_node_id;
                    m_err     = 1'b0;
                    m_armed   = 1'b1;
                end else begin
                    m_err   = 1'b1;
                    m_armed = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        m_n++;
    endtask

    task automatic wait_tune(output bit found);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (tune_en) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("tune_seen", found, 1'b1);
    endtask

    initial begin
        logic [15:0] v;
        int          hold;
        bit          found;

        // Reset state, then release with a valid pending id.
        m_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        repeat (12) cycle();
        chk("first_lock", rx_locked, 1'b1);
        chk("first_chan", channel_sel, 16'd2);
        chk("first_count", retune_count, 8'd1);

        // Out of range, then own id: both errors, channel held.
        data_rx_node_id = 16'd5;
        repeat (3) cycle();
        chk("range_err", rx_error, 1'b1);
        chk("range_chan", channel_sel, 16'd2);
        data_rx_node_id = 16'd0;
        repeat (3) cycle();
        chk("self_err", rx_error, 1'b1);
        chk("self_count", retune_count, 8'd1);
        data_rx_node_id = 16'd2;
        repeat (12) cycle();

        // Retarget at the fourth settle cycle.
        data_rx_node_id = 16'd1;
        repeat (5) cycle();
        data_rx_node_id = 16'd3;
        repeat (14) cycle();
        chk("retarget_chan", channel_sel, 16'd3);

        // Reset in the middle of settling.
        data_rx_node_id = 16'd1;
        repeat (4) cycle();
        rst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (12) cycle();
        chk("post_reset_count", retune_count, 8'd1);
        chk("post_reset_lock", rx_locked, 1'b1);

        // Back-to-back valid requests until the counter saturates.
        max_node = 16'd16;
        node_id  = 16'd0;
        for (int i = 0; i < 300; i++) begin
            v = 16'($urandom_range(1, 15));
            while (v == data_rx_node_id) v = 16'($urandom_range(1, 15));
            data_rx_node_id = v;
            cycle();
            cycle();
        end
        repeat (3) cycle();
        chk("saturate", retune_count, 8'd255);

        // Random requests, ring sizes and own ids.
        for (int s = 0; s < 40; s++) begin
            max_node        = 16'($urandom_range(2, 8));
            node_id         = 16'($urandom_range(0, 7));
            data_rx_node_id = 16'($urandom_range(0, 9));
            hold            = $urandom_range(1, 14);
            for (int c = 0; c < hold; c++) begin
                if (c == 2 && $urandom_range(0, 1) == 1) max_node = 16'($urandom_range(0, 8));
                cycle();
            end
        end

`ifdef RX_CHAN_LOCK_TIMEOUT_EN
        // No lock indication: error 32 cycles after the strobe.
        rst = 1'b0;
        lock_ok = 1'b0;
        max_node = 16'd4;
        node_id = 16'd0;
        data_rx_node_id = 16'd2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_tune(found);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk("timeout_error", rx_error, k >= 32);
            chk("timeout_locked", rx_locked, 1'b0);
        end

        // Lock indication at cycle 12 after the strobe.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_tune(found);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            lock_ok = (k == 12);
            @(negedge clk);
            chk("late_lock", rx_locked, k >= 13);
            chk("late_lock_err", rx_error, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
